guess_entry_ctrl: RTL and testbench

//  Keyboard-side front end of the guess path. It accepts letter, backspace and enter key events and keeps a

---
 rtl/wordle_pkg.sv | 30 +++
 rtl/slot_ptr.sv | 44 ++++
 rtl/guess_entry_ctrl.sv | 161 ++++++++++++++++
 tb/tb_guess_entry_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// ---------------------------------------------------------------------------
// wordle_pkg
// Shared constants and types for the guess entry path.
//   LETTER_W   : width of a letter code (1..26 = 'a'..'z', 0 = empty slot)
//   WORD_LEN   : letters per guess
//   ADDR_W     : slot address width, matches the 3-to-8 slot decoder input
//   LETTER_MIN : lowest legal letter code
//   LETTER_MAX : highest legal letter code
//   state_t    : controller state encodings
// ---------------------------------------------------------------------------
package wordle_pkg;

    localparam int LETTER_W   = 5;
    localparam int WORD_LEN   = 5;
    localparam int ADDR_W     = 3;
    localparam int LETTER_MIN = 1;
    localparam int LETTER_MAX = 26;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_SUBMIT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    // True when a key code names a real letter rather than empty/unused codes
    function automatic logic letter_in_range(input logic [LETTER_W-1:0] code);
        return (code >= LETTER_W'(LETTER_MIN)) && (code <= LETTER_W'(LETTER_MAX));
    endfunction

endpackage

// File: rtl/slot_ptr.sv
// ---------------------------------------------------------------------------
// slot_ptr
// Write pointer over the letter slots: an up/down counter that never wraps.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low clear
//   inc      : step up by one (ignored when full)
//   dec      : step down by one (ignored at zero)
//   load0    : force the pointer back to zero (highest priority)
//   value    : current pointer, 0..WORD_LEN
//   full     : value has reached WORD_LEN
// ---------------------------------------------------------------------------
module slot_ptr #(
    parameter int ADDR_W   = 3,
    parameter int WORD_LEN = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              load0,
    output logic [ADDR_W-1:0] value,
    output logic              full
);

    localparam logic [ADDR_W-1:0] FULL_VAL = ADDR_W'(WORD_LEN);

    assign full = (value == FULL_VAL);

    // Saturating counter: the caller already filters illegal steps, the
    // guards here just make the no-wrap property hold locally as well.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load0) begin
            value <= '0;
        end else if (inc && !full) begin
            value <= value + 1'b1;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/guess_entry_ctrl.sv
// ---------------------------------------------------------------------------
// guess_entry_ctrl
// Keyboard-side front end of the guess path. Letter/backspace/enter events
// fill WORD_LEN shadow slots through the slot decoder; a full word on enter
// is offered to the scoring stage, after which every slot is wiped.
// Ports:
//   clock, reset_n        : clock and asynchronous active-low reset
//   key_valid, key_code   : letter key event and its code
//   key_back, key_enter   : backspace and enter events
//   key_ready             : key events are accepted (ENTRY state)
//   slot_addr, slot_wr_en : decoder address and write strobe
//   slot_data             : letter written into the addressed slot
//   count                 : letters currently held
//   reject                : one-cycle pulse for a dropped illegal event
//   guess_valid/ready     : handshake towards the scoring stage
//   guess_word            : slot i at bits [i*LETTER_W +: LETTER_W]
// ---------------------------------------------------------------------------
module guess_entry_ctrl
    import wordle_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         key_valid,
    input  logic [LETTER_W-1:0]          key_code,
    input  logic                         key_back,
    input  logic                         key_enter,
    output logic                         key_ready,
    output logic [ADDR_W-1:0]            slot_addr,
    output logic                         slot_wr_en,
    output logic [LETTER_W-1:0]          slot_data,
    output logic [ADDR_W-1:0]            count,
    output logic                         reject,
    output logic                         guess_valid,
    input  logic                         guess_ready,
    output logic [WORD_LEN*LETTER_W-1:0] guess_word
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_LEN - 1);

    state_t                      state;
    logic [ADDR_W-1:0]           ptr;
    logic                        ptr_full;
    logic [ADDR_W-1:0]           ptr_prev;
    logic [ADDR_W-1:0]           clr_next;
    logic [WORD_LEN*LETTER_W-1:0] shadow;

    logic enter_ok, enter_bad;
    logic back_ok, back_bad;
    logic letter_ok, letter_bad;
    logic handshake;
    logic clear_last;

    slot_ptr #(
        .ADDR_W   (ADDR_W),
        .WORD_LEN (WORD_LEN)
    ) u_slot_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (letter_ok),
        .dec     (back_ok),
        .load0   (clear_last),
        .value   (ptr),
        .full    (ptr_full)
    );

    assign count      = ptr;
    assign guess_word = shadow;
    assign ptr_prev   = ptr - 1'b1;
    assign clr_next   = slot_addr + 1'b1;

    // Decode the single winning key event for this cycle. Enter beats back,
    // back beats letter; losers are silently dropped. Outside ENTRY nothing
    // is decoded, so ignored keys never raise reject.
    always_comb begin
        enter_ok   = 1'b0;
        enter_bad  = 1'b0;
        back_ok    = 1'b0;
        back_bad   = 1'b0;
        letter_ok  = 1'b0;
        letter_bad = 1'b0;
        if (state == ST_ENTRY) begin
            if (key_enter) begin
                enter_ok  = ptr_full;
                enter_bad = !ptr_full;
            end else if (key_back) begin
                back_ok  = (ptr != '0);
                back_bad = (ptr == '0);
            end else if (key_valid) begin
                letter_ok  = !ptr_full && letter_in_range(key_code);
                letter_bad = !letter_ok;
            end
        end
        handshake  = (state == ST_SUBMIT) && guess_valid && guess_ready;
        clear_last = (state == ST_CLEAR) && (slot_addr == LAST_ADDR);
    end

    // Controller FSM with registered outputs and the shadow slots. The wipe
    // reuses slot_addr as its step index: the handshake edge issues the
    // write to slot 0, and each CLEAR cycle advances until the last slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_ENTRY;
            key_ready   <= 1'b1;
            slot_addr   <= '0;
            slot_wr_en  <= 1'b0;
            slot_data   <= '0;
            reject      <= 1'b0;
            guess_valid <= 1'b0;
            shadow      <= '0;
        end else begin
            slot_wr_en <= 1'b0;
            reject     <= enter_bad | back_bad | letter_bad;
            case (state)
                ST_ENTRY: begin
                    if (enter_ok) begin
                        state       <= ST_SUBMIT;
                        key_ready   <= 1'b0;
                        guess_valid <= 1'b1;
                    end else if (back_ok) begin
                        slot_addr  <= ptr_prev;
                        slot_data  <= '0;
                        slot_wr_en <= 1'b1;
                        shadow[int'(ptr_prev)*LETTER_W +: LETTER_W] <= '0;
                    end else if (letter_ok) begin
                        slot_addr  <= ptr;
                        slot_data  <= key_code;
                        slot_wr_en <= 1'b1;
                        shadow[int'(ptr)*LETTER_W +: LETTER_W] <= key_code;
                    end
                end
                ST_SUBMIT: begin
                    if (handshake) begin
                        state       <= ST_CLEAR;
                        guess_valid <= 1'b0;
                        slot_addr   <= '0;
                        slot_data   <= '0;
                        slot_wr_en  <= 1'b1;
                        shadow[LETTER_W-1:0] <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clear_last) begin
                        state     <= ST_ENTRY;
                        key_ready <= 1'b1;
                    end else begin
                        slot_addr  <= clr_next;
                        slot_data  <= '0;
                        slot_wr_en <= 1'b1;
                        shadow[int'(clr_next)*LETTER_W +: LETTER_W] <= '0;
                    end
                end
                default: begin
                    state       <= ST_ENTRY;
                    key_ready   <= 1'b1;
                    guess_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_guess_entry_ctrl
// Directed bench for guess_entry_ctrl: letter entry, rejects, backspace,
// submit handshake with back-pressure, slot wipe, key priority and an
// asynchronous reset in the middle of the wipe.
// ---------------------------------------------------------------------------
module tb_guess_entry_ctrl;

    logic        clock;
    logic        reset_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_back;
    logic        key_enter;
    logic        key_ready;
    logic [2:0]  slot_addr;
    logic        slot_wr_en;
    logic [4:0]  slot_data;
    logic [2:0]  count;
    logic        reject;
    logic        guess_valid;
    logic        guess_ready;
    logic [24:0] guess_word;

    int n_checks = 0;
    int n_fails  = 0;

    guess_entry_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_back    (key_back),
        .key_enter   (key_enter),
        .key_ready   (key_ready),
        .slot_addr   (slot_addr),
        .slot_wr_en  (slot_wr_en),
        .slot_data   (slot_data),
        .count       (count),
        .reject      (reject),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .guess_word  (guess_word)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle's key inputs
    task automatic apply_stimulus(input logic kv, input logic [4:0] code,
                                  input logic back, input logic enter);
        key_valid = kv;
        key_code  = code;
        key_back  = back;
        key_enter = enter;
    endtask

    // Advance past the next rising edge and settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int          word_a[5];
        int          word_b[5];
        logic [24:0] exp_word;

        word_a = '{3, 1, 20, 19, 5};
        word_b = '{1, 2, 3, 4, 5};
        guess_ready = 1'b0;
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0);

        // Reset values
        reset_n = 1'b0;
        #12;
        check_output("rst_key_ready", 32'(key_ready), 32'd1);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("rst_addr", 32'(slot_addr), 32'd0);
        check_output("rst_reject", 32'(reject), 32'd0);
        check_output("rst_valid", 32'(guess_valid), 32'd0);
        check_output("rst_word", 32'(guess_word), 32'd0);
        reset_n = 1'b1;

        // Five letters on consecutive cycles, each written one cycle later
        $display("[TB] letter entry");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 5'(word_a[i]), 1'b0, 1'b0);
            tick();
            check_output($sformatf("t1_wr_en_%0d", i), 32'(slot_wr_en), 32'd1);
            check_output($sformatf("t1_addr_%0d", i), 32'(slot_addr), 32'(i));
            check_output($sformatf("t1_data_%0d", i), 32'(slot_data), 32'(word_a[i]));
            check_output($sformatf("t1_count_%0d", i), 32'(count), 32'(i + 1));
            check_output($sformatf("t1_reject_%0d", i), 32'(reject), 32'd0);
        end

        // Letter while full is rejected, then backspace clears slot 4
        apply_stimulus(1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        check_output("t2_full_reject", 32'(reject), 32'd1);
        check_output("t2_full_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("t2_full_count", 32'(count), 32'd5);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("t2_reject_pulse", 32'(reject), 32'd0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_output("t2_back_wr_en", 32'(slot_wr_en), 32'd1);
        check_output("t2_back_addr", 32'(slot_addr), 32'd4);
        check_output("t2_back_data", 32'(slot_data), 32'd0);
        check_output("t2_back_count", 32'(count), 32'd4);
        exp_word = {5'd0, 5'd19, 5'd20, 5'd1, 5'd3};
        check_output("t2_back_word", 32'(guess_word), 32'(exp_word));

        // Letter code boundaries: 27 rejected, 26 accepted
        apply_stimulus(1'b1, 5'd27, 1'b0, 1'b0);
        tick();
        check_output("t2_code27_reject", 32'(reject), 32'd1);
        check_output("t2_code27_count", 32'(count), 32'd4);
        apply_stimulus(1'b1, 5'd26, 1'b0, 1'b0);
        tick();
        check_output("t2_code26_data", 32'(slot_data), 32'd26);
        check_output("t2_code26_reject", 32'(reject), 32'd0);
        check_output("t2_code26_count", 32'(count), 32'd5);

        // Back down to two letters, enter is rejected there
        for (int i = 4; i >= 2; i--) begin
            apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
            tick();
            check_output($sformatf("t3_back_addr_%0d", i), 32'(slot_addr), 32'(i));
            check_output($sformatf("t3_back_count_%0d", i), 32'(count), 32'(i));
        end
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check_output("t3_enter_reject", 32'(reject), 32'd1);
        check_output("t3_enter_valid", 32'(guess_valid), 32'd0);
        check_output("t3_enter_key_ready", 32'(key_ready), 32'd1);
        check_output("t3_enter_count", 32'(count), 32'd2);
        for (int i = 1; i >= 0; i--) begin
            apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
            tick();
            check_output($sformatf("t3_back_addr_%0d", i), 32'(slot_addr), 32'(i));
        end
        check_output("t3_empty_count", 32'(count), 32'd0);
        apply_stimulus(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_output("t3_back0_reject", 32'(reject), 32'd1);
        check_output("t3_back0_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("t3_back0_count", 32'(count), 32'd0);
        apply_stimulus(1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("t3_code0_reject", 32'(reject), 32'd1);
        check_output("t3_code0_count", 32'(count), 32'd0);

        // "crate" + enter, scoring stage stalls for three cycles
        $display("[TB] submit and wipe");
        word_a = '{3, 18, 1, 20, 5};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 5'(word_a[i]), 1'b0, 1'b0);
            tick();
        end
        check_output("t4_full_count", 32'(count), 32'd5);
        exp_word = {5'd5, 5'd20, 5'd1, 5'd18, 5'd3};
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check_output("t4_valid", 32'(guess_valid), 32'd1);
        check_output("t4_key_ready", 32'(key_ready), 32'd0);
        check_output("t4_enter_reject", 32'(reject), 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 5'd7, 1'b1, 1'b0);
            tick();
            check_output($sformatf("t4_hold_valid_%0d", i), 32'(guess_valid), 32'd1);
            check_output($sformatf("t4_hold_word_%0d", i), 32'(guess_word), 32'(exp_word));
            check_output($sformatf("t4_hold_wr_en_%0d", i), 32'(slot_wr_en), 32'd0);
            check_output($sformatf("t4_hold_reject_%0d", i), 32'(reject), 32'd0);
            check_output($sformatf("t4_hold_count_%0d", i), 32'(count), 32'd5);
        end
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0);
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
        check_output("t4_hs_valid_drop", 32'(guess_valid), 32'd0);
        check_output("t4_clr_wr_en_0", 32'(slot_wr_en), 32'd1);
        check_output("t4_clr_addr_0", 32'(slot_addr), 32'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check_output($sformatf("t4_clr_wr_en_%0d", i), 32'(slot_wr_en), 32'd1);
            check_output($sformatf("t4_clr_addr_%0d", i), 32'(slot_addr), 32'(i));
            check_output($sformatf("t4_clr_data_%0d", i), 32'(slot_data), 32'd0);
            check_output($sformatf("t4_clr_key_ready_%0d", i), 32'(key_ready), 32'd0);
        end
        tick();
        check_output("t4_done_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("t4_done_key_ready", 32'(key_ready), 32'd1);
        check_output("t4_done_count", 32'(count), 32'd0);
        check_output("t4_done_word", 32'(guess_word), 32'd0);

        // All three key events at once while full: enter wins
        $display("[TB] priority and reset mid-wipe");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 5'(word_b[i]), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 5'd9, 1'b1, 1'b1);
        tick();
        check_output("t5_valid", 32'(guess_valid), 32'd1);
        check_output("t5_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("t5_reject", 32'(reject), 32'd0);
        check_output("t5_count", 32'(count), 32'd5);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0);

        // Handshake, then reset once the wipe reaches slot 2
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
        tick();
        tick();
        check_output("t6_pre_addr", 32'(slot_addr), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t6_rst_key_ready", 32'(key_ready), 32'd1);
        check_output("t6_rst_wr_en", 32'(slot_wr_en), 32'd0);
        check_output("t6_rst_addr", 32'(slot_addr), 32'd0);
        check_output("t6_rst_count", 32'(count), 32'd0);
        check_output("t6_rst_valid", 32'(guess_valid), 32'd0);
        check_output("t6_rst_word", 32'(guess_word), 32'd0);
        #2;
        reset_n = 1'b1;
        apply_stimulus(1'b1, 5'd12, 1'b0, 1'b0);
        tick();
        check_output("t6_after_addr", 32'(slot_addr), 32'd0);
        check_output("t6_after_data", 32'(slot_data), 32'd12);
        check_output("t6_after_count", 32'(count), 32'd1);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
